// File: rtl/mission_sequencer.sv
// Purpose: top-level mission FSM for the pick-and-deliver robot (follow, grab, turn, return, release).
// Latency: outputs are registered and decoded from next-state, so they change on the same edge as state.
// Backpressure: none; sensor inputs are level-sampled every cycle and debounced internally.
module mission_sequencer #(
  parameter logic [9:0]  TARGET_DST   = 10'd500,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned GRIP_CYCLES  = 50_000_000,
  parameter int unsigned LOST_TIMEOUT = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] IPS,
  input  logic       midIPS,
  input  logic [1:0] IR,
  input  logic [9:0] dst,
  output logic [2:0] move_cmd,
  output logic       grip_cmd,
  output logic [2:0] state,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_GRAB    = 3'd2,
    S_TURN    = 3'd3,
    S_RETURN  = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6,
    S_FAULT   = 3'd7
  } state_e;

  localparam logic [2:0] MV_STOP   = 3'd0;
  localparam logic [2:0] MV_FOLLOW = 3'd1;
  localparam logic [2:0] MV_TURN_L = 3'd2;

  // Debounce counters saturate at DEBOUNCE; one timer serves dwell and timeouts.
  localparam int unsigned DW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned MAXC = (GRIP_CYCLES > LOST_TIMEOUT) ? GRIP_CYCLES : LOST_TIMEOUT;
  localparam int unsigned TW   = $clog2(MAXC + 1);

  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DEB_M1  = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(MAXC);
  localparam logic [TW-1:0] GRIP_M1 = TW'(GRIP_CYCLES - 1);
  localparam logic [TW-1:0] LOST_M1 = TW'(LOST_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] tgt_cnt_q, tgt_cnt_d;
  logic [DW-1:0] junc_cnt_q, junc_cnt_d;
  logic [DW-1:0] mid_cnt_q, mid_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          seen_low_q, seen_low_d;
  logic [2:0]    move_q, move_d;
  logic          grip_q, grip_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic tgt, lost, junc;
  logic tgt_acc, junc_acc, mid_acc;
  logic lost_to, dwell_end, entering;

  // Next-state, counter updates and output decode from the next state.
  always_comb begin
    tgt  = (IR != 2'b00) && (dst == TARGET_DST);
    lost = (IPS == 2'b00) && !midIPS;
    junc = (IPS == 2'b11) && midIPS;

    // A condition is accepted on the sample that completes DEBOUNCE in a row.
    tgt_acc   = tgt    && (tgt_cnt_q  >= DEB_M1);
    junc_acc  = junc   && (junc_cnt_q >= DEB_M1);
    mid_acc   = midIPS && (mid_cnt_q  >= DEB_M1);
    lost_to   = tmr_q >= LOST_M1;
    dwell_end = tmr_q >= GRIP_M1;

    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_FOLLOW;
      S_FOLLOW: begin
        if (tgt_acc)              state_d = S_GRAB;
        else if (lost && lost_to) state_d = S_FAULT;
      end
      S_GRAB:    if (dwell_end) state_d = S_TURN;
      S_TURN: begin
        // Only reacquire after the centre sensor has left the old line.
        if (seen_low_q && mid_acc) state_d = S_RETURN;
        else if (lost_to)          state_d = S_FAULT;
      end
      S_RETURN: begin
        if (junc_acc)             state_d = S_RELEASE;
        else if (lost && lost_to) state_d = S_FAULT;
      end
      S_RELEASE: if (dwell_end) state_d = S_DONE;
      default: ;
    endcase

    entering = (state_d != state_q);

    tgt_cnt_d  = tgt_cnt_q;
    junc_cnt_d = junc_cnt_q;
    mid_cnt_d  = mid_cnt_q;
    tmr_d      = tmr_q;
    seen_low_d = seen_low_q;
    if (entering) begin
      tgt_cnt_d  = '0;
      junc_cnt_d = '0;
      mid_cnt_d  = '0;
      tmr_d      = '0;
      seen_low_d = 1'b0;
    end else begin
      tgt_cnt_d  = !tgt    ? '0 : (tgt_cnt_q  == DEB_MAX) ? tgt_cnt_q  : tgt_cnt_q  + 1'b1;
      junc_cnt_d = !junc   ? '0 : (junc_cnt_q == DEB_MAX) ? junc_cnt_q : junc_cnt_q + 1'b1;
      mid_cnt_d  = !midIPS ? '0 : (mid_cnt_q  == DEB_MAX) ? mid_cnt_q  : mid_cnt_q  + 1'b1;
      seen_low_d = seen_low_q | !midIPS;
      // While following, the timer measures the current lost run; elsewhere, time in state.
      if ((state_q == S_FOLLOW || state_q == S_RETURN) && !lost) tmr_d = '0;
      else if (tmr_q != TMR_MAX)                                 tmr_d = tmr_q + 1'b1;
    end

    move_d  = MV_STOP;
    grip_d  = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      S_FOLLOW: move_d = MV_FOLLOW;
      S_GRAB:   grip_d = 1'b1;
      S_TURN:   begin move_d = MV_TURN_L; grip_d = 1'b1; end
      S_RETURN: begin move_d = MV_FOLLOW; grip_d = 1'b1; end
      S_DONE:   done_d = 1'b1;
      // Keep whatever the gripper was doing so a carried payload is not dropped.
      S_FAULT:  begin grip_d = grip_q; fault_d = 1'b1; end
      default: ;
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tgt_cnt_q  <= '0;
      junc_cnt_q <= '0;
      mid_cnt_q  <= '0;
      tmr_q      <= '0;
      seen_low_q <= 1'b0;
      move_q     <= MV_STOP;
      grip_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_cnt_q  <= tgt_cnt_d;
      junc_cnt_q <= junc_cnt_d;
      mid_cnt_q  <= mid_cnt_d;
      tmr_q      <= tmr_d;
      seen_low_q <= seen_low_d;
      move_q     <= move_d;
      grip_q     <= grip_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
    end
  end

  assign state    = state_q;
  assign move_cmd = move_q;
  assign grip_cmd = grip_q;
  assign done     = done_q;
  assign fault    = fault_q;

endmodule

// File: doc/mission_sequencer.md
Name: mission_sequencer

Overview:
Top-level mission controller for the line-following pick-and-deliver robot. It sequences motor modes and the gripper, using the IPS line sensors, the IR beacon presence and the decoded beacon frequency (dst). It sits between the sensor/frequency-decode datapath and the motor/servo drivers. Its single command word replaces the ad-hoc coupling of motor and servo logic to the raw IR inputs.

Parameters:
TARGET_DST, 10'd500, beacon frequency code (dst value) marking the pickup station
DEBOUNCE, 4, consecutive cycles a sensor condition must hold before it is accepted (min 1)
GRIP_CYCLES, 50_000_000, dwell cycles in GRAB and RELEASE (0.5 s at 100 MHz; min 1)
LOST_TIMEOUT, 25_000_000, cycles of lost line (FOLLOW/RETURN) or no reacquire (TURN) before FAULT

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high; takes effect on the rising edge of clk
start  in  1  mission start; level sampled, honoured only in IDLE or DONE
IPS  in  2  left/right line sensors, 1 = line seen
midIPS  in  1  centre line sensor, 1 = line seen
IR  in  2  beacon receivers, nonzero = beacon present
dst  in  10  decoded beacon frequency code, valid while IR != 0
move_cmd  out  3  0 STOP, 1 FOLLOW, 2 TURN_L, 3 TURN_R (unused), 4 REVERSE (unused)
grip_cmd  out  1  1 = close gripper, 0 = open
state  out  3  current state encoding (for the seven-seg/debug)
done  out  1  mission complete flag
fault  out  1  mission aborted flag

Behaviour:
- All outputs are registered. They are decoded from next-state, so an output changes on the same edge the state changes.
- Reset value: state = IDLE (0), move_cmd = 0, grip_cmd = 0, done = 0, fault = 0. All counters = 0.
- Reset applies from any state, including mid-GRAB with the gripper closed: the gripper opens.
- Derived conditions, evaluated each cycle:
  - tgt = (IR != 0) && (dst == TARGET_DST)
  - lost = (IPS == 2'b00) && !midIPS
  - junc = (IPS == 2'b11) && midIPS
- Debounce: each condition has its own counter that saturates at DEBOUNCE.
  - The counter clears on any cycle the condition is false.
  - The condition is accepted on the edge at which its DEBOUNCE-th consecutive true sample is taken.
- State-entry rule: the dwell/timeout counter and all debounce counters clear on every state entry.
- States (encoding, outputs, transitions):
  - IDLE (0): STOP, grip 0. start=1 -> FOLLOW.
  - FOLLOW (1): FOLLOW, grip 0.
    - tgt accepted -> GRAB.
    - Else lost held for LOST_TIMEOUT consecutive cycles -> FAULT.
    - On the same edge, tgt wins over timeout.
  - GRAB (2): STOP, grip 1. Exactly GRIP_CYCLES cycles in state, then -> TURN.
  - TURN (3): TURN_L, grip 1.
    - Sets an internal flag once midIPS has been 0 for at least one cycle.
    - With the flag set, midIPS=1 accepted -> RETURN.
    - LOST_TIMEOUT cycles in TURN without this -> FAULT.
  - RETURN (4): FOLLOW, grip 1.
    - junc accepted -> RELEASE.
    - Lost timeout -> FAULT, as in FOLLOW; junc wins a same-edge tie.
  - RELEASE (5): STOP, grip 0. Exactly GRIP_CYCLES cycles, then -> DONE.
  - DONE (6): STOP, grip 0, done 1.
    - start=1 -> FOLLOW; done clears on that edge.
  - FAULT (7): STOP, fault 1. grip_cmd holds its value from before entry (payload not dropped). Exit only via reset.
- start is ignored in states 1–5 and 7.
- tgt is ignored outside FOLLOW; a beacon seen while carrying does not retrigger GRAB.
- Counters are wide enough for max(GRIP_CYCLES, LOST_TIMEOUT) with no wrap. Timeout and dwell counters saturate.

Test Plan:
(Bench parameters: DEBOUNCE=3, GRIP_CYCLES=8, LOST_TIMEOUT=20, TARGET_DST=500.)
1. Reset, then start pulse at cycle 5 -> state=1 and move_cmd=1 from the edge sampling start. Assert reset at cycle 12 -> all outputs return to reset values at the next edge.
2. FOLLOW with IR=2'b01 and dst=500 for 3 cycles -> GRAB on the 3rd edge, grip_cmd=1, move_cmd=0. State=3 exactly 8 cycles later. dst=499 for 10 cycles -> no transition.
3. TURN: midIPS 1→0 for 2 cycles, then 1 for 3 cycles -> RETURN on the 3rd high edge. Holding midIPS=1 throughout -> FAULT after 20 cycles, with grip_cmd kept at 1.
4. RETURN: IPS=11 with midIPS=1 for 3 cycles -> RELEASE, grip_cmd=0. DONE (done=1) after 8 cycles. A new start -> FOLLOW with done=0.
5. FOLLOW with IPS=00, midIPS=0 for 19 cycles, then 1 cycle of line -> no fault. 20 consecutive lost cycles -> state=7, fault=1.
6. Tie: on the cycle lost reaches its 20th count, tgt also reaches its 3rd debounce count -> GRAB, not FAULT.
